// File: rtl/plab4_net_ring_route_sched.sv
// Ring router output scheduler: greedy route per input, per-output packet-hold arbitration.
// Define PLAB4_NET_ROUTE_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module plab4_net_ring_route_sched #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  localparam int c_dest_nbits = $clog2(p_num_routers)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                in_val,
  output logic [2:0]                in_rdy,
  input  logic [3*c_dest_nbits-1:0] in_dest,
  input  logic [2:0]                in_last,
  output logic [2:0]                out_val,
  input  logic [2:0]                out_rdy,
  output logic [5:0]                xbar_sel
);

  localparam logic [c_dest_nbits-1:0] c_id = p_router_id[c_dest_nbits-1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q [3];
  state_t     state_d [3];
  logic [1:0] owner_q [3];
  logic [1:0] owner_d [3];
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
  logic [1:0] ptr_q [3];
  logic [1:0] ptr_d [3];
`endif

  logic [2:0][1:0] route;
  logic [2:0]      owned;

  // Modular distances on the ring; a tie resolves toward PREV.
  for (genvar gi = 0; gi < 3; gi++) begin : g_route
    logic [c_dest_nbits-1:0] dest;
    logic [c_dest_nbits-1:0] forw;
    logic [c_dest_nbits-1:0] backw;
    assign dest  = in_dest[gi*c_dest_nbits +: c_dest_nbits];
    assign forw  = dest - c_id;
    assign backw = c_id - dest;
    assign route[gi] = (dest == c_id) ? 2'd1 : ((forw < backw) ? 2'd2 : 2'd0);
  end

  always_comb begin
    owned = '0;
    for (int o = 0; o < 3; o++) begin
      if (state_q[o] == BUSY) owned[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    logic [2:0] cand;
    logic [2:0] idx;
    logic [1:0] g;
    logic       gv;
    in_rdy   = '0;
    out_val  = '0;
    xbar_sel = '0;
    cand     = '0;
    idx      = '0;
    g        = '0;
    gv       = 1'b0;
    for (int o = 0; o < 3; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
      ptr_d[o]   = ptr_q[o];
`endif
      for (int i = 0; i < 3; i++) begin
        cand[i] = in_val[i] && (route[i] == o[1:0]) && !owned[i];
      end
      gv = 1'b0;
      g  = '0;
      if (state_q[o] == BUSY) begin
        gv = 1'b1;
        g  = owner_q[o];
      end else begin
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
        for (int k = 0; k < 3; k++) begin
          idx = {1'b0, ptr_q[o]} + k[2:0];
          if (idx >= 3'd3) idx = idx - 3'd3;
          if (!gv && cand[idx]) begin
            gv = 1'b1;
            g  = idx[1:0];
          end
        end
`else
        for (int k = 0; k < 3; k++) begin
          if (!gv && cand[k]) begin
            gv = 1'b1;
            g  = k[1:0];
          end
        end
`endif
      end
      // Outputs are forced quiet while reset is held, even combinationally.
      if (gv && reset) begin
        out_val[o]         = in_val[g];
        xbar_sel[2*o +: 2] = g;
        in_rdy[g]          = out_rdy[o];
        if (in_val[g] && out_rdy[o]) begin
          if (state_q[o] == IDLE) begin
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
            ptr_d[o] = (g == 2'd2) ? 2'd0 : g + 2'd1;
`endif
            if (!in_last[g]) begin
              state_d[o] = BUSY;
              owner_d[o] = g;
            end
          end else if (in_last[g]) begin
            state_d[o] = IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 2'd0;
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
        ptr_q[o]   <= 2'd0;
`endif
      end
    end else begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
        ptr_q[o]   <= ptr_d[o];
`endif
      end
    end
  end

endmodule

// File: tb/tb_plab4_net_ring_route_sched.sv
// Bench for plab4_net_ring_route_sched: packet-level reference model checked every cycle, plus directed literals.
module tb_plab4_net_ring_route_sched;
  localparam int ID = 2;
  localparam int N  = 8;
`ifdef PLAB4_NET_ROUTE_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] in_val = '0;
  logic [2:0] in_rdy;
  logic [8:0] in_dest = '0;
  logic [2:0] in_last = '0;
  logic [2:0] out_val;
  logic [2:0] out_rdy = '0;
  logic [5:0] xbar_sel;

  always #5 clk = ~clk;

  plab4_net_ring_route_sched #(.p_router_id(ID), .p_num_routers(N)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_dest(in_dest), .in_last(in_last),
    .out_val(out_val), .out_rdy(out_rdy), .xbar_sel(xbar_sel)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Output index a packet to dest must leave on: 0=prev, 1=eject, 2=next.
  function automatic int route_of(int dest);
    int forw, backw;
    if (dest == ID) return 1;
    forw  = (dest - ID + N) % N;
    backw = (ID - dest + N) % N;
    return (forw < backw) ? 2 : 0;
  endfunction

  // Reference model: which input holds each output, and the RR start point.
  int m_busy [3];
  int m_owner[3];
  int m_ptr  [3];
  int m_owned[3];
  int g, cand_i;
  logic [2:0] e_val, e_rdy;
  logic [5:0] e_sel;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_out_val", out_val, 0);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_xbar_sel", xbar_sel, 0);
      for (int o = 0; o < 3; o++) begin
        m_busy[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
      end
    end else begin
      e_val = '0; e_rdy = '0; e_sel = '0;
      for (int i = 0; i < 3; i++) m_owned[i] = 0;
      for (int o = 0; o < 3; o++) if (m_busy[o] != 0) m_owned[m_owner[o]] = 1;
      for (int o = 0; o < 3; o++) begin
        g = -1;
        if (m_busy[o] != 0) g = m_owner[o];
        else begin
          for (int k = 0; k < 3; k++) begin
            cand_i = RR ? (m_ptr[o] + k) % 3 : k;
            if (g < 0 && in_val[cand_i] && route_of(int'(in_dest[cand_i*3 +: 3])) == o
                && m_owned[cand_i] == 0)
              g = cand_i;
          end
        end
        if (g >= 0) begin
          e_val[o]        = in_val[g];
          e_sel[2*o +: 2] = g[1:0];
          e_rdy[g]        = out_rdy[o];
          if (in_val[g] && out_rdy[o]) begin
            if (m_busy[o] == 0) begin
              m_ptr[o] = (g + 1) % 3;
              if (!in_last[g]) begin
                m_busy[o] = 1; m_owner[o] = g;
              end
            end else if (in_last[g]) begin
              m_busy[o] = 0;
            end
          end
        end
      end
      chk("model_out_val", out_val, e_val);
      chk("model_in_rdy", in_rdy, e_rdy);
      chk("model_xbar_sel", xbar_sel, e_sel);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] v, logic [2:0] d0, logic [2:0] d1, logic [2:0] d2,
                       logic [2:0] last, logic [2:0] rdy);
    in_val  = v;
    in_dest = {d2, d1, d0};
    in_last = last;
    out_rdy = rdy;
  endtask

  task automatic expect_now(string nm, logic [2:0] v, logic [5:0] s, logic [2:0] r);
    #1;
    chk({nm, "_out_val"}, out_val, v);
    chk({nm, "_xbar_sel"}, xbar_sel, s);
    chk({nm, "_in_rdy"}, in_rdy, r);
  endtask

  logic [2:0] dl [4];
  logic [5:0] exp_sel [4];
  logic [2:0] exp_val [4];

  initial begin
    // Reset held with live requests: outputs must stay quiet.
    drive(3'b111, 3'd2, 3'd3, 3'd1, 3'b111, 3'b111);
    expect_now("reset_hold", 3'b000, 6'b000000, 3'b000);
    step();
    step();
    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 3'b111);

    // Single-flit routes from input 1 for router 2.
    dl[0] = 3'd2; dl[1] = 3'd3; dl[2] = 3'd0; dl[3] = 3'd6;
    exp_val[0] = 3'b010; exp_val[1] = 3'b100; exp_val[2] = 3'b001; exp_val[3] = 3'b001;
    exp_sel[0] = 6'b000100; exp_sel[1] = 6'b010000; exp_sel[2] = 6'b000001; exp_sel[3] = 6'b000001;
    for (int t = 0; t < 4; t++) begin
      step();
      drive(3'b010, 0, dl[t], 0, 3'b010, 3'b111);
      expect_now("route", exp_val[t], exp_sel[t], 3'b010);
    end
    step(); drive(3'b000, 0, 0, 0, 0, 3'b111);

    // Packet hold: input 2 waits for input 0's tail on output 2.
    step(); drive(3'b001, 3'd3, 0, 0, 3'b000, 3'b111);
    expect_now("hold_head", 3'b100, 6'b000000, 3'b001);
    step(); drive(3'b101, 3'd2, 0, 3'd3, 3'b100, 3'b111);
    expect_now("hold_body", 3'b100, 6'b000000, 3'b001);
    step(); drive(3'b101, 3'd2, 0, 3'd3, 3'b101, 3'b111);
    expect_now("hold_tail", 3'b100, 6'b000000, 3'b001);
    step(); drive(3'b100, 0, 0, 3'd3, 3'b100, 3'b111);
    expect_now("hold_next", 3'b100, 6'b100000, 3'b100);
    step(); drive(3'b000, 0, 0, 0, 0, 3'b111);

    // Arbitration between inputs 0 and 1 on the eject port, from a fresh reset.
    reset = 1'b0;
    @(negedge clk); #1; reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step(); drive(3'b011, 3'd2, 3'd2, 0, 3'b011, 3'b111);
      #1;
      chk("arb_sel", xbar_sel[3:2], (RR && (t % 2 == 1)) ? 2'd1 : 2'd0);
      chk("arb_rdy", in_rdy, (RR && (t % 2 == 1)) ? 3'b010 : 3'b001);
    end
    step(); drive(3'b000, 0, 0, 0, 0, 3'b111);

    // Backpressure on a BUSY output, then drain.
    step(); drive(3'b001, 3'd3, 0, 0, 3'b000, 3'b111);
    expect_now("bp_head", 3'b100, 6'b000000, 3'b001);
    for (int t = 0; t < 4; t++) begin
      step(); drive(3'b001, 3'd5, 0, 0, 3'b000, 3'b011);
      expect_now("bp_stall", 3'b100, 6'b000000, 3'b000);
    end
    for (int t = 0; t < 3; t++) begin
      step(); drive(3'b001, 3'd5, 0, 0, (t == 2) ? 3'b001 : 3'b000, 3'b111);
      expect_now("bp_drain", 3'b100, 6'b000000, 3'b001);
    end
    step(); drive(3'b000, 0, 0, 0, 0, 3'b111);

    // Asynchronous reset mid-packet with output 0 owned by input 2.
    step(); drive(3'b100, 0, 0, 3'd1, 3'b000, 3'b111);
    expect_now("ar_head", 3'b001, 6'b000010, 3'b100);
    step(); drive(3'b100, 0, 0, 3'd1, 3'b000, 3'b111);
    #1; reset = 1'b0;
    expect_now("ar_assert", 3'b000, 6'b000000, 3'b000);
    step();
    reset = 1'b1;
    drive(3'b010, 0, 3'd0, 0, 3'b010, 3'b111);
    expect_now("ar_after", 3'b001, 6'b000001, 3'b010);

    // All three outputs transfer together.
    step(); drive(3'b111, 3'd2, 3'd3, 3'd1, 3'b111, 3'b111);
    expect_now("parallel", 3'b111, 6'b010010, 3'b111);

    // Randomized traffic, with occasional reset pulses spanning a check edge.
    for (int t = 0; t < 3000; t++) begin
      step();
      reset   = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      in_val  = 3'($urandom);
      in_dest = 9'($urandom);
      for (int i = 0; i < 3; i++) begin
        in_last[i] = ($urandom_range(0, 2) == 0);
        out_rdy[i] = ($urandom_range(0, 3) != 0);
      end
    end
    step(); reset = 1'b1; drive(3'b000, 0, 0, 0, 0, 3'b111);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plab4_net_ring_route_sched.md
# plab4_net_ring_route_sched

Per-router output scheduler for the ring network. Each cycle it takes the three input channels (from prev router, local injection, from next router) and computes each head flit's greedy route. It then arbitrates every output channel (prev, terminal eject, next) among the inputs that request it. It holds each grant for the whole packet, until the tail flit transfers, and drives the crossbar selects and the val/rdy handshakes.

## Interface
- p_router_id, 0, this router's ring position
- p_num_routers, 8, routers on ring; must be a power of two ≥ 2
- c_dest_nbits, $clog2(p_num_routers), dest field width; derived, not set externally
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- in_val  input  3  per-input flit valid; index 0=prev, 1=term (inject), 2=next
- in_rdy  output  3  per-input ready
- in_dest  input  3*c_dest_nbits  per-input dest field, input i at bits [i*c_dest_nbits +: c_dest_nbits]; sampled only on head flits
- in_last  input  3  per-input tail flag; 1 marks the packet's final flit (single-flit packet has head=tail)
- out_val  output  3  per-output valid; index 0=prev, 1=term (eject), 2=next
- out_rdy  input  3  per-output ready from downstream
- xbar_sel  output  6  per-output crossbar select, output o at bits [2*o +: 2], value = granted input index

## Operation
- Route per input: forw = (dest − p_router_id) mod 2^c_dest_nbits; backw = (p_router_id − dest) mod 2^c_dest_nbits. Route is TERM if dest == p_router_id, else NEXT if forw < backw, else PREV. A tie goes to PREV. Output mapping: PREV→0, TERM→1, NEXT→2.
- Each output o has a state machine with states IDLE and BUSY, plus a 2-bit owner register.
- IDLE: the candidates are inputs with in_val=1, route==o, and not currently owner of any BUSY output. The winner is chosen by the arbiter (see Configuration). Output drives out_val[o]=1, xbar_sel[o]=winner, in_rdy[winner]=out_rdy[o].
- IDLE transfer (in_val & in_rdy for the winner):
  - in_last=0: go to BUSY, owner←winner.
  - in_last=1: stay IDLE.
- BUSY: only the owner is connected. out_val[o]=in_val[owner], xbar_sel[o]=owner, in_rdy[owner]=out_rdy[o]. The owner's in_dest is ignored. A transfer with in_last=1 returns the output to IDLE.
- An input not granted by any output has in_rdy=0. An output with no grant drives out_val=0 and xbar_sel=2'b00.
- An input targets at most one output per cycle, so grants never conflict. All three outputs may transfer in the same cycle.
- U-turn routes are legal, e.g. input 0 routed to PREV.

## Timing
- Zero-latency grant: route compute, arbitration and handshake are combinational within the cycle. A head flit presented with out_rdy=1 transfers in the same cycle.
- State (owner, BUSY flag, RR pointers) updates on the clk edge after a transfer. A new head can win an output in the cycle after the tail transfers.
- Stall: out_rdy=0 holds the grant. In IDLE the winner may change next cycle if in_val changes; in BUSY the owner never changes until its tail transfers.
- Reset (reset=0), including mid-packet: all outputs go IDLE, owners 0, RR pointers 0. While asserted, out_val=0, in_rdy=0, xbar_sel=0. Partial packets are dropped; clearing them upstream is the surrounding network's job.

## Configuration
- PLAB4_NET_ROUTE_SCHED_RR_EN defined: each output keeps a 2-bit round-robin pointer (reset 0).
  - The search runs pointer, pointer+1, pointer+2 (mod 3); the first candidate found wins.
  - On an IDLE head transfer, the pointer ← (winner+1) mod 3.
  - BUSY cycles do not move the pointer.
- Undefined: fixed priority, input 0 > input 1 > input 2. No pointer registers exist.

## Test plan
- Config p_router_id=2, p_num_routers=8. Single-flit head on input 1 with dest=2, 3, 0, 6, in_last=1, out_rdy=3'b111 → routes TERM (out 1), NEXT (out 2), PREV (out 0, backw 2), PREV (out 0, tie 4/4). Each transfers the same cycle.
- 3-flit packet input 0 dest=3 (→out 2), and input 2 raises a head for dest=3 on flit 2 → input 2 in_rdy=0 until input 0's tail transfers. Input 2 is granted the next cycle. Body flits with dest=2 are still sent to out 2.
- RR_EN: inputs 0 and 1 both send continuous single-flit dest=2 → out 1 grants alternate 0,1,0,1. Without RR_EN → always input 0.
- Backpressure: out_rdy[2]=0 for 4 cycles during a BUSY packet → out_val[2]=1 is held, xbar_sel[2] is constant, no transfer, state stays BUSY. Deassert → the remaining flits drain.
- Async reset=0 mid-packet (out 0 BUSY owner 2) with no clk edge → out_val, in_rdy, xbar_sel go to 0 immediately. After release, a new head on input 1 for dest=0 is granted out 0 at once.
- Parallel: inputs 0, 1, 2 with dest 2, 3, 1 (→ TERM, NEXT, PREV) → all three outputs transfer in one cycle.
